// File: rtl/regfile_stack_ctrl_pkg.sv
// Shared definitions for the register file / stack controller: flag bit
// positions, general register indices and stack sequencer state encodings.
package regfile_stack_ctrl_pkg;

    localparam int unsigned FLAG_C = 0;
    localparam int unsigned FLAG_Z = 1;
    localparam int unsigned FLAG_I = 2;
    localparam int unsigned FLAG_D = 3;
    localparam int unsigned FLAG_B = 4;
    localparam int unsigned FLAG_V = 6;
    localparam int unsigned FLAG_N = 7;

    localparam int unsigned REG_ACC = 0;
    localparam int unsigned REG_X   = 1;
    localparam int unsigned REG_Y   = 2;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_PUSH = 2'd1,
        ST_POP  = 2'd2
    } stk_state_e;

endpackage

// File: rtl/regfile_stack_seq.sv
// Stack sequencer: owns SP and occupancy, runs push/pop through a req/ack
// memory port and flags overflow/underflow on rejected requests.
module regfile_stack_seq
    import regfile_stack_ctrl_pkg::*;
#(
    parameter int unsigned DATA_W     = 8,
    parameter int unsigned ADDR_W     = 16,
    parameter int unsigned STACK_PAGE = 1
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              sp_write,
    input  logic [DATA_W-1:0] sp_wdata,
    output logic [DATA_W-1:0] sp_out,
    input  logic              push_req,
    input  logic              pop_req,
    input  logic [DATA_W-1:0] push_data,
    output logic              stk_busy,
    output logic [DATA_W-1:0] pop_data,
    output logic              pop_valid,
    output logic              stk_ovf,
    output logic              stk_unf,
    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    input  logic              mem_ack
);

    localparam int unsigned PAGE_W = ADDR_W - DATA_W;
    localparam int unsigned OCC_W  = DATA_W + 1;
    localparam logic [OCC_W-1:0]  OCC_FULL = {1'b1, {DATA_W{1'b0}}};
    localparam logic [OCC_W-1:0]  OCC_TOP  = {1'b0, {DATA_W{1'b1}}};
    localparam logic [PAGE_W-1:0] PAGE     = PAGE_W'(STACK_PAGE);

    stk_state_e        state_q, state_d;
    logic [DATA_W-1:0] sp_q, sp_d;
    logic [OCC_W-1:0]  occ_q, occ_d;
    logic [DATA_W-1:0] data_q, data_d;
    logic [DATA_W-1:0] pop_data_q, pop_data_d;
    logic              pop_valid_q, pop_valid_d;
    logic              ovf_q, ovf_d;
    logic              unf_q, unf_d;
    logic              mem_req_q, mem_req_d;
    logic              mem_we_q, mem_we_d;
    logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
    logic              busy_q, busy_d;
    logic [DATA_W-1:0] sp_addr;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= ST_IDLE;
            sp_q        <= '1;
            occ_q       <= '0;
            data_q      <= '0;
            pop_data_q  <= '0;
            pop_valid_q <= 1'b0;
            ovf_q       <= 1'b0;
            unf_q       <= 1'b0;
            mem_req_q   <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            sp_q        <= sp_d;
            occ_q       <= occ_d;
            data_q      <= data_d;
            pop_data_q  <= pop_data_d;
            pop_valid_q <= pop_valid_d;
            ovf_q       <= ovf_d;
            unf_q       <= unf_d;
            mem_req_q   <= mem_req_d;
            mem_we_q    <= mem_we_d;
            mem_addr_q  <= mem_addr_d;
            busy_q      <= busy_d;
        end
    end

    // Memory port outputs are decoded from the next state so they appear the
    // cycle after accept and drop the cycle after ack.
    always_comb begin
        state_d     = state_q;
        sp_d        = sp_q;
        occ_d       = occ_q;
        data_d      = data_q;
        pop_data_d  = pop_data_q;
        pop_valid_d = 1'b0;
        ovf_d       = 1'b0;
        unf_d       = 1'b0;

        unique case (state_q)
            ST_IDLE: begin
                if (push_req) begin
                    if (occ_q == OCC_FULL) begin
                        ovf_d = 1'b1;
                    end else begin
                        data_d  = push_data;
                        state_d = ST_PUSH;
                    end
                end else if (pop_req) begin
                    if (occ_q == '0) begin
                        unf_d = 1'b1;
                    end else begin
                        state_d = ST_POP;
                    end
                end else if (sp_write) begin
                    sp_d  = sp_wdata;
                    occ_d = OCC_TOP - OCC_W'(sp_wdata);
                end
            end
            ST_PUSH: begin
                if (mem_ack) begin
                    sp_d    = sp_q - DATA_W'(1);
                    occ_d   = occ_q + OCC_W'(1);
                    state_d = ST_IDLE;
                end
            end
            ST_POP: begin
                if (mem_ack) begin
                    pop_data_d  = mem_rdata;
                    pop_valid_d = 1'b1;
                    sp_d        = sp_q + DATA_W'(1);
                    occ_d       = occ_q - OCC_W'(1);
                    state_d     = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        sp_addr    = (state_d == ST_POP) ? sp_d + DATA_W'(1) : sp_d;
        mem_req_d  = (state_d != ST_IDLE);
        mem_we_d   = (state_d == ST_PUSH);
        mem_addr_d = {PAGE, sp_addr};
        busy_d     = (state_d != ST_IDLE);
    end

    assign sp_out    = sp_q;
    assign stk_busy  = busy_q;
    assign pop_data  = pop_data_q;
    assign pop_valid = pop_valid_q;
    assign stk_ovf   = ovf_q;
    assign stk_unf   = unf_q;
    assign mem_req   = mem_req_q;
    assign mem_we    = mem_we_q;
    assign mem_addr  = mem_addr_q;
    assign mem_wdata = data_q;

endmodule

// File: rtl/regfile_stack_ctrl.sv
// CPU register file (GPRs, PC, masked flags) with an attached stack
// sequencer driving a req/ack memory port.
module regfile_stack_ctrl
    import regfile_stack_ctrl_pkg::*;
#(
    parameter int unsigned DATA_W     = 8,
    parameter int unsigned ADDR_W     = 16,
    parameter int unsigned NUM_GPR    = 4,
    parameter int unsigned STACK_PAGE = 1,
    parameter int unsigned PC_RESET   = 0
) (
    input  logic                       clk,
    input  logic                       reset_n,
    input  logic                       wr_en,
    input  logic [$clog2(NUM_GPR)-1:0] wr_sel,
    input  logic [DATA_W-1:0]          wr_data,
    input  logic [$clog2(NUM_GPR)-1:0] rd_sel_a,
    input  logic [$clog2(NUM_GPR)-1:0] rd_sel_b,
    output logic [DATA_W-1:0]          rd_data_a,
    output logic [DATA_W-1:0]          rd_data_b,
    input  logic                       pc_load,
    input  logic                       pc_inc,
    input  logic [ADDR_W-1:0]          pc_load_val,
    output logic [ADDR_W-1:0]          pc_out,
    input  logic [DATA_W-1:0]          flags_mask,
    input  logic [DATA_W-1:0]          flags_in,
    output logic [DATA_W-1:0]          flags_out,
    input  logic                       sp_write,
    input  logic [DATA_W-1:0]          sp_wdata,
    output logic [DATA_W-1:0]          sp_out,
    input  logic                       push_req,
    input  logic                       pop_req,
    input  logic [DATA_W-1:0]          push_data,
    output logic                       stk_busy,
    output logic [DATA_W-1:0]          pop_data,
    output logic                       pop_valid,
    output logic                       stk_ovf,
    output logic                       stk_unf,
    output logic                       mem_req,
    output logic                       mem_we,
    output logic [ADDR_W-1:0]          mem_addr,
    output logic [DATA_W-1:0]          mem_wdata,
    input  logic [DATA_W-1:0]          mem_rdata,
    input  logic                       mem_ack
);

    localparam int unsigned SEL_W     = $clog2(NUM_GPR);
    localparam int unsigned GPR_SLOTS = 2 ** SEL_W;

    // Slots above NUM_GPR exist only so every select value decodes; they stay 0.
    logic [DATA_W-1:0] gpr_q [GPR_SLOTS];
    logic [ADDR_W-1:0] pc_q;
    logic [DATA_W-1:0] flags_q;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < GPR_SLOTS; i++) gpr_q[i] <= '0;
        end else if (wr_en) begin
            for (int i = 0; i < NUM_GPR; i++) begin
                if (wr_sel == SEL_W'(i)) gpr_q[i] <= wr_data;
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            pc_q <= ADDR_W'(PC_RESET);
        end else if (pc_load) begin
            pc_q <= pc_load_val;
        end else if (pc_inc) begin
            pc_q <= pc_q + ADDR_W'(1);
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            flags_q <= '0;
        end else begin
            flags_q <= (flags_q & ~flags_mask) | (flags_in & flags_mask);
        end
    end

    assign rd_data_a = gpr_q[rd_sel_a];
    assign rd_data_b = gpr_q[rd_sel_b];
    assign pc_out    = pc_q;
    assign flags_out = flags_q;

    regfile_stack_seq #(
        .DATA_W     (DATA_W),
        .ADDR_W     (ADDR_W),
        .STACK_PAGE (STACK_PAGE)
    ) u_seq (
        .clk       (clk),
        .reset_n   (reset_n),
        .sp_write  (sp_write),
        .sp_wdata  (sp_wdata),
        .sp_out    (sp_out),
        .push_req  (push_req),
        .pop_req   (pop_req),
        .push_data (push_data),
        .stk_busy  (stk_busy),
        .pop_data  (pop_data),
        .pop_valid (pop_valid),
        .stk_ovf   (stk_ovf),
        .stk_unf   (stk_unf),
        .mem_req   (mem_req),
        .mem_we    (mem_we),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_rdata (mem_rdata),
        .mem_ack   (mem_ack)
    );

endmodule
